// File: rtl/lcd_char_if.sv
// Character handshake between the BCD string writer and the LCD writer.
// The master presents one ASCII character and its position per transfer.
interface lcd_char_if #(
  parameter int IDX_W = 3
) ();
  logic             char_valid;
  logic             char_ready;
  logic [7:0]       lcd_data;
  logic [IDX_W-1:0] char_idx;

  modport master (
    output char_valid,
    output lcd_data,
    output char_idx,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  lcd_data,
    input  char_idx,
    output char_ready
  );
endinterface

// File: rtl/lcd_bcd_string_writer.sv
// Streams a latched multi-digit BCD value as ASCII characters, MSB first,
// with optional separators and leading-zero blanking.
module lcd_bcd_string_writer #(
  parameter int         NUM_DIGITS = 6,
  parameter int         SEP_EVERY  = 2,
  parameter logic [7:0] SEP_CHAR   = 8'h3A,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_blank,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  lcd_char_if.master              lcd
);

  localparam int SEP_DIV   = (SEP_EVERY > 0) ? SEP_EVERY : 1;
  localparam int NUM_CHARS = NUM_DIGITS +
    ((SEP_EVERY > 0) ? (NUM_DIGITS - 1) / SEP_DIV : 0);
  localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    lz_q;
  logic [4:0]              dptr_q;
  logic [4:0]              gcnt_q;
  logic                    zrun_q;

  logic [4*NUM_DIGITS-1:0] gv;
  logic                    glz;
  logic [4:0]              gd;
  logic [4:0]              gg;
  logic                    gz;
  logic [3:0]              nib;
  logic                    is_sep;
  logic                    is_zero;
  logic                    is_bad;
  logic                    is_last;
  logic [7:0]              ch;
  logic [4:0]              nxt_d;
  logic [4:0]              nxt_g;
  logic                    nxt_z;
  logic                    nxt_err;
  logic                    last_char;

  // In IDLE the first character is built straight from the inputs so it
  // can be registered on the same edge that accepts START.
  always_comb begin
    gv  = (state == IDLE) ? bcd_in   : val_q;
    glz = (state == IDLE) ? lz_blank : lz_q;
    gd  = (state == IDLE) ? 5'd0     : dptr_q;
    gg  = (state == IDLE) ? 5'd0     : gcnt_q;
    gz  = (state == IDLE) ? 1'b1     : zrun_q;
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (gd == 5'(i)) nib = gv[4*(NUM_DIGITS-1-i) +: 4];
    end
    is_sep  = (SEP_EVERY > 0) && (gg == 5'(SEP_EVERY));
    is_zero = (nib == 4'h0);
    is_bad  = (nib > 4'd9);
    is_last = (gd == 5'(NUM_DIGITS - 1));
    if (is_sep)
      ch = SEP_CHAR;
    else if (glz && gz && is_zero && !is_last)
      ch = BLANK_CHAR;
    else if (is_bad)
      ch = 8'h30;
    else
      ch = 8'h30 + {4'h0, nib};
    nxt_d   = is_sep ? gd : gd + 5'd1;
    nxt_g   = is_sep ? 5'd0 : gg + 5'd1;
    nxt_z   = is_sep ? gz : (gz && is_zero);
    nxt_err = !is_sep && is_bad;
  end

  assign last_char = (lcd.char_idx == IDX_W'(NUM_CHARS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      val_q          <= '0;
      lz_q           <= 1'b0;
      dptr_q         <= 5'd0;
      gcnt_q         <= 5'd0;
      zrun_q         <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      lcd.char_valid <= 1'b0;
      lcd.lcd_data   <= 8'h20;
      lcd.char_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            val_q          <= bcd_in;
            lz_q           <= lz_blank;
            err            <= nxt_err;
            lcd.char_valid <= 1'b1;
            lcd.lcd_data   <= ch;
            lcd.char_idx   <= '0;
            dptr_q         <= nxt_d;
            gcnt_q         <= nxt_g;
            zrun_q         <= nxt_z;
            busy           <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (lcd.char_ready) begin
            if (last_char) begin
              lcd.char_valid <= 1'b0;
              done           <= 1'b1;
              state          <= FIN;
            end else begin
              lcd.char_idx <= lcd.char_idx + 1'b1;
              lcd.lcd_data <= ch;
              dptr_q       <= nxt_d;
              gcnt_q       <= nxt_g;
              zrun_q       <= nxt_z;
              err          <= err | nxt_err;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bcd_string_writer.sv
// Scoreboard bench: a string-level model fills per-DUT queues and
// negedge monitors pop and compare every accepted character.
module tb_lcd_bcd_string_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        start_a, lz_a, busy_a, done_a, err_a;
  logic [23:0] bcd_a;
  logic        start_b, lz_b, busy_b, done_b, err_b;
  logic [15:0] bcd_b;

  lcd_char_if #(.IDX_W(3)) ifa ();
  lcd_char_if #(.IDX_W(2)) ifb ();

  lcd_bcd_string_writer #(
    .NUM_DIGITS(6), .SEP_EVERY(2)
  ) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a),
    .bcd_in(bcd_a), .lz_blank(lz_a), .busy(busy_a),
    .done(done_a), .err(err_a), .lcd(ifa)
  );

  lcd_bcd_string_writer #(
    .NUM_DIGITS(4), .SEP_EVERY(0)
  ) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b),
    .bcd_in(bcd_b), .lz_blank(lz_b), .busy(busy_b),
    .done(done_b), .err(err_b), .lcd(ifb)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          exp_err;
  int          done_cnt = 0;
  int          bp = 0;
  int          held = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected string from the display rules: digits MSB first, blanking
  // while every digit so far is zero, separator after each group.
  function automatic void model(input int dut, input logic [63:0] v,
                                input int nd, input int se, input bit lz);
    bit         allz = 1'b1;
    int         c = 0;
    logic [3:0] n;
    logic [7:0] ch;
    logic [15:0] e;
    exp_err = 1'b0;
    for (int d = 0; d < nd; d++) begin
      n = v[4*(nd-1-d) +: 4];
      if (n != 0) allz = 1'b0;
      if (lz && allz && d != nd - 1) ch = 8'h20;
      else if (n > 9) begin ch = 8'h30; exp_err = 1'b1; end
      else ch = 8'h30 + 8'(n);
      e = {8'(c), ch};
      if (dut == 0) qa.push_back(e); else qb.push_back(e);
      c++;
      if (se > 0 && (d + 1) % se == 0 && d + 1 < nd) begin
        e = {8'(c), 8'h3A};
        if (dut == 0) qa.push_back(e); else qb.push_back(e);
        c++;
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (bp == 0)
      ifa.char_ready = 1'b1;
    else if (bp == 1)
      ifa.char_ready = ($urandom_range(0, 3) != 0);
    else if (ifa.char_valid && ifa.char_idx == 3'd2 && held < 5) begin
      ifa.char_ready = 1'b0;
      held++;
    end else
      ifa.char_ready = 1'b1;
  end

  logic        pv, pr, last_a, last_b;
  logic [7:0]  pd;
  logic [2:0]  pi;
  logic [15:0] ea, eb;

  always @(negedge clk) begin
    if (!resetn) begin
      pv = 1'b0;
      last_a = 1'b0;
    end else begin
      if (done_a) done_cnt++;
      if (last_a) begin
        chk("done_after_last", done_a, 1);
        last_a = 1'b0;
      end
      if (pv && !pr) begin
        chk("hold_valid", ifa.char_valid, 1);
        chk("hold_data", ifa.lcd_data, pd);
        chk("hold_idx", ifa.char_idx, pi);
      end
      if (ifa.char_valid && ifa.char_ready) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_char_a: got %0h expected none",
                   ifa.lcd_data);
        end else begin
          ea = qa.pop_front();
          chk("data_a", ifa.lcd_data, ea[7:0]);
          chk("idx_a", ifa.char_idx, ea[15:8]);
          if (qa.size() == 0) last_a = 1'b1;
        end
      end
      pv = ifa.char_valid;
      pr = ifa.char_ready;
      pd = ifa.lcd_data;
      pi = ifa.char_idx;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      last_b = 1'b0;
    end else begin
      if (last_b) begin
        chk("done_after_last_b", done_b, 1);
        last_b = 1'b0;
      end
      if (ifb.char_valid && ifb.char_ready) begin
        if (qb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_char_b: got %0h expected none",
                   ifb.lcd_data);
        end else begin
          eb = qb.pop_front();
          chk("data_b", ifb.lcd_data, eb[7:0]);
          chk("idx_b", ifb.char_idx, eb[15:8]);
          if (qb.size() == 0) last_b = 1'b1;
        end
      end
    end
  end

  task automatic run_a(input logic [23:0] v, input bit lz, input bit poke);
    bit got = 1'b0;
    model(0, {40'h0, v}, 6, 2, lz);
    @(posedge clk); #1;
    start_a = 1'b1; bcd_a = v; lz_a = lz;
    @(posedge clk); #1;
    start_a = 1'b0; bcd_a = ~v; lz_a = ~lz;
    @(negedge clk);
    chk("busy_on", busy_a, 1);
    chk("err_start", err_a, v[23:20] > 4'd9);
    if (poke) begin
      @(posedge clk); #1;
      start_a = 1'b1; bcd_a = 24'($urandom);
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done_a) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("busy_at_done", busy_a, 1);
    chk("err_done", err_a, exp_err);
    chk("q_empty_a", qa.size(), 0);
    @(negedge clk);
    chk("busy_off", busy_a, 0);
    chk("done_pulse", done_a, 0);
  endtask

  task automatic run_b(input logic [15:0] v, input bit lz);
    bit got = 1'b0;
    model(1, {48'h0, v}, 4, 0, lz);
    @(posedge clk); #1;
    start_b = 1'b1; bcd_b = v; lz_b = lz;
    @(posedge clk); #1;
    start_b = 1'b0; bcd_b = ~v;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done_b) got = 1'b1;
    end
    chk("done_seen_b", got, 1);
    chk("q_empty_b", qb.size(), 0);
    @(negedge clk);
    chk("busy_off_b", busy_b, 0);
  endtask

  initial begin
    bit          hit;
    int          dc;
    int          k;
    logic [23:0] v;
    resetn = 1'b0;
    start_a = 1'b0; bcd_a = '0; lz_a = 1'b0;
    start_b = 1'b0; bcd_b = '0; lz_b = 1'b0;
    ifa.char_ready = 1'b1;
    ifb.char_ready = 1'b1;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", ifa.char_valid, 0);
    chk("rst_data", ifa.lcd_data, 8'h20);
    chk("rst_idx", ifa.char_idx, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    resetn = 1'b1;

    run_a(24'h123456, 1'b0, 1'b0);
    run_a(24'h000705, 1'b1, 1'b0);
    run_a(24'h000705, 1'b0, 1'b0);
    run_a(24'h000000, 1'b1, 1'b0);
    bp = 2; held = 0;
    run_a(24'h123456, 1'b0, 1'b0);
    chk("stall_cycles", held, 5);
    bp = 0;
    run_a(24'h12AB56, 1'b0, 1'b0);
    run_a(24'h654321, 1'b0, 1'b0);
    run_a(24'h987654, 1'b1, 1'b1);

    model(0, {40'h0, 24'h112233}, 6, 2, 1'b0);
    @(posedge clk); #1;
    start_a = 1'b1; bcd_a = 24'h112233; lz_a = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (ifa.char_valid && ifa.char_idx == 3'd4) hit = 1'b1;
    end
    chk("reach_idx4", hit, 1);
    dc = done_cnt;
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", ifa.char_valid, 0);
    chk("abort_data", ifa.lcd_data, 8'h20);
    chk("abort_idx", ifa.char_idx, 0);
    chk("abort_done", done_a, 0);
    qa.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_abort", done_cnt, dc);
    run_a(24'h112233, 1'b1, 1'b0);

    run_b(16'h0930, 1'b0);
    run_b(16'h0007, 1'b1);

    bp = 1;
    for (int t = 0; t < 20; t++) begin
      v = '0;
      for (int d = 0; d < 6; d++) begin
        if ($urandom_range(0, 7) == 0)
          v[4*d +: 4] = 4'($urandom_range(10, 15));
        else
          v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      k = $urandom_range(0, 6);
      for (int d = 0; d < k; d++) v[4*(5-d) +: 4] = 4'h0;
      run_a(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bp = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_bcd_string_writer.md
Name: lcd_bcd_string_writer

Overview:
Parametrised successor to the single-digit BCD-to-ASCII LCD decoder. Latches a packed multi-digit BCD value and streams it MSB-digit-first as ASCII characters to the LCD character writer over a valid/ready handshake. Optionally inserts a separator character every SEP_EVERY digits and blanks leading zeros. It sits between the clock/alarm time registers and the LCD controller, for display strings such as "12:34:56".

Parameters:
NUM_DIGITS, 6, number of BCD digits (1..16)
SEP_EVERY, 2, insert separator after every SEP_EVERY digits counted from the MSB; 0 = no separators
SEP_CHAR, 8'h3A, separator character (':')
BLANK_CHAR, 8'h20, replacement character for blanked leading zeros (space)
Derived, not overridable: NUM_CHARS = NUM_DIGITS + (SEP_EVERY>0 ? (NUM_DIGITS-1)/SEP_EVERY : 0); IDX_W = max(1, clog2(NUM_CHARS))

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
START  in  1  begin a string transfer; sampled only while idle
BCD_IN  in  4*NUM_DIGITS  packed BCD value; bits [4*NUM_DIGITS-1 -: 4] are the most significant digit
LZ_BLANK  in  1  leading-zero blanking enable; latched with START
BUSY  out  1  high from the cycle after START is accepted until the cycle DONE is asserted (inclusive)
CHAR_VALID  out  1  LCD_DATA holds a valid character
CHAR_READY  in  1  LCD writer accepts the character
LCD_DATA  out  8  ASCII character
CHAR_IDX  out  IDX_W  position of the current character, 0 = leftmost
DONE  out  1  one-cycle pulse after the last character transfers
ERR  out  1  sticky: a latched digit was >9; cleared when the next START is accepted

Behaviour:
- Reset (asynchronous, RESETN=0): state IDLE; BUSY=0, CHAR_VALID=0, LCD_DATA=8'h20, CHAR_IDX=0, DONE=0, ERR=0; the latched BCD value and blanking flag are cleared. Reset mid-string aborts the transfer immediately. No DONE is issued for the aborted string.
- States: IDLE, SEND, FIN.
- IDLE: START=1 at an edge -> latch BCD_IN and LZ_BLANK, clear ERR, go to SEND with char 0 presented. CHAR_VALID rises on the next cycle (latency 1 clock).
- SEND: CHAR_VALID=1. LCD_DATA and CHAR_IDX stay stable while CHAR_READY=0.
  - On CHAR_VALID & CHAR_READY: if CHAR_IDX = NUM_CHARS-1, go to FIN (CHAR_VALID=0 the next cycle); otherwise advance CHAR_IDX and present the next char in the next cycle.
  - Back-to-back transfers sustain one char per clock.
- FIN: DONE=1 for exactly one cycle, BUSY=1, then IDLE. A new START is accepted from the following IDLE cycle.
- START while in SEND or FIN is ignored; the latched value is unaffected by BCD_IN changes during a transfer.
- Character sequence: walk digits MSB to LSB. After digit d (1-based from MSB), if SEP_EVERY>0, d mod SEP_EVERY = 0 and d < NUM_DIGITS, emit SEP_CHAR.
- Digit mapping: 0..9 -> 8'h30 + digit. Nibbles 10..15 -> 8'h30 and set ERR (at presentation).
- Blanking (LZ_BLANK=1): a digit is blanked (BLANK_CHAR) when it and all more significant digits are 0. The least significant digit is never blanked. Separators are always emitted unchanged. An invalid nibble counts as nonzero and ends blanking.
- With LZ_BLANK=0, zeros are emitted as 8'h30.

Test Plan:
- NUM_DIGITS=6, SEP_EVERY=2, BCD_IN=24'h123456, LZ_BLANK=0, CHAR_READY=1 -> 8 chars 31 32 3A 33 34 3A 35 36, CHAR_IDX 0..7, DONE pulse one cycle after char 7, BUSY low afterwards.
- BCD_IN=24'h000705, LZ_BLANK=1 -> 20 20 3A 20 37 3A 30 35. Same value with LZ_BLANK=0 -> 30 30 3A 30 37 3A 30 35. BCD_IN=0 with LZ_BLANK=1 -> last char 30.
- Backpressure: hold CHAR_READY=0 for 5 cycles on char 2 -> LCD_DATA=3A and CHAR_IDX=2 stable throughout, no skipped or duplicated chars, total 8 transfers.
- BCD_IN=24'h12AB56 -> chars 31 32 3A 30 30 3A 35 36; ERR=1 after char 3 and held through DONE; next START with a valid value clears ERR.
- START pulsed mid-transfer and BCD_IN changed -> ignored, original string completes. RESETN low at char 4 -> outputs at reset values asynchronously, no DONE. After release, a fresh START yields the full string.
- SEP_EVERY=0, NUM_DIGITS=4, BCD_IN=16'h0930 -> 4 chars 30 39 33 30, CHAR_IDX 0..3.
